// File: rtl/timer_pkg.sv
// Shared definitions for the timer group: register offsets,
// CONFIG field layout and the CONFIG pack/unpack helpers.
package timer_pkg;

  localparam logic [7:0] OFS_CONFIG  = 8'h00;
  localparam logic [7:0] OFS_LO      = 8'h04;
  localparam logic [7:0] OFS_HI      = 8'h08;
  localparam logic [7:0] OFS_UPDATE  = 8'h0C;
  localparam logic [7:0] OFS_ALARMLO = 8'h10;
  localparam logic [7:0] OFS_ALARMHI = 8'h14;
  localparam logic [7:0] OFS_LOADLO  = 8'h18;
  localparam logic [7:0] OFS_LOADHI  = 8'h1C;
  localparam logic [7:0] OFS_LOAD    = 8'h20;
  localparam logic [31:0] SET_SIZE   = 32'h24;

  localparam logic [7:0] INT_ENA_OFS = 8'h00;
  localparam logic [7:0] INT_RAW_OFS = 8'h04;
  localparam logic [7:0] INT_ST_OFS  = 8'h08;
  localparam logic [7:0] INT_CLR_OFS = 8'h0C;

  localparam int CFG_EN       = 31;
  localparam int CFG_INC      = 30;
  localparam int CFG_AR       = 29;
  localparam int CFG_DIV_HI   = 28;
  localparam int CFG_DIV_LO   = 13;
  localparam int CFG_ALARM_EN = 10;

  typedef struct packed {
    logic        en;
    logic        inc;
    logic        autoreload;
    logic [15:0] divider;
    logic        alarm_en;
  } timer_cfg_t;

  function automatic logic [31:0] cfg_pack(timer_cfg_t c);
    logic [31:0] d;
    d = '0;
    d[CFG_EN] = c.en;
    d[CFG_INC] = c.inc;
    d[CFG_AR] = c.autoreload;
    d[CFG_DIV_HI:CFG_DIV_LO] = c.divider;
    d[CFG_ALARM_EN] = c.alarm_en;
    return d;
  endfunction

  function automatic timer_cfg_t cfg_unpack(logic [31:0] d);
    timer_cfg_t c;
    c.en = d[CFG_EN];
    c.inc = d[CFG_INC];
    c.autoreload = d[CFG_AR];
    c.divider = d[CFG_DIV_HI:CFG_DIV_LO];
    c.alarm_en = d[CFG_ALARM_EN];
    return c;
  endfunction

endpackage

// File: rtl/timer_group_if.sv
// MMIO bus bundle between the processor and the timer group,
// including the per-channel interrupt lines.
interface timer_group_if #(parameter int N_CH = 2);
  logic [31:0]     addr_in;
  logic [31:0]     data_in;
  logic            wr_in;
  logic            rd_in;
  logic            rd_valid_out;
  logic [31:0]     data_out;
  logic [N_CH-1:0] irq_out;

  modport master (
    output addr_in, data_in, wr_in, rd_in,
    input  rd_valid_out, data_out, irq_out
  );

  modport slave (
    input  addr_in, data_in, wr_in, rd_in,
    output rd_valid_out, data_out, irq_out
  );
endinterface

// File: rtl/timer_channel.sv
// One timer: prescaler, up/down counter, alarm compare,
// software snapshot and load/auto-reload.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  timer_cfg_t       cfg,
  input  logic             load,
  input  logic             update,
  input  logic [CNT_W-1:0] alarm,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] snap,
  output logic             alarm_hit
);

  logic [15:0]      psc;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             reload;
  logic             div_one;

  assign div_one = cfg.divider <= 16'd1;
  assign tick = cfg.en & (div_one | (psc >= cfg.divider - 16'd1));
  assign alarm_hit = cfg.en & cfg.alarm_en & (cnt == alarm);
  assign reload = alarm_hit & cfg.autoreload;

  // prescaler restarts whenever the count phase is re-established
  always_ff @(posedge clk or posedge rst) begin
    if (rst) psc <= '0;
    else if (!cfg.en || load || reload || tick) psc <= '0;
    else psc <= psc + 16'd1;
  end

  // counter: load beats reload beats tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (load || reload) cnt <= load_val;
    else if (tick) cnt <= cfg.inc ? cnt + 1'b1 : cnt - 1'b1;
  end

  // snapshot holds the pre-edge count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) snap <= '0;
    else if (update) snap <= cnt;
  end

endmodule

// File: rtl/timer_group.sv
// MMIO timer group: address decode, per-channel register file,
// shared interrupt block and registered read mux.
module timer_group
  import timer_pkg::*;
#(
  parameter int          N_CH      = 2,
  parameter int          CNT_W     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h3FF5_F000,
  parameter logic [15:0] CH_STRIDE = 16'h0024,
  parameter logic [15:0] INT_OFS   = 16'h0098
) (
  input logic          clk,
  input logic          rst,
  timer_group_if.slave bus
);

  localparam int HI_W = CNT_W - 32;

  logic [31:0]     off;
  logic [31:0]     ch_rdata [N_CH];
  logic [N_CH-1:0] hit_vec;
  logic [N_CH-1:0] ena;
  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] st;
  logic [N_CH-1:0] clr_mask;
  logic [31:0]     rmux;
  logic            r_ena, r_raw, r_st, w_ena, w_clr;

  assign off = bus.addr_in - BASE_ADDR;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [31:0]      rel;
    logic             sel;
    logic             a_cfg, a_lo, a_hi, a_upd, a_alo, a_ahi;
    logic             a_llo, a_lhi, a_ld;
    timer_cfg_t       cfg;
    logic [CNT_W-1:0] alarm, load_val, snap;
    logic             alarm_hit;
    logic [31:0]      rv;

    assign rel = off - (32'(c) * 32'(CH_STRIDE));
    assign sel = rel < SET_SIZE;
    assign a_cfg = sel & (rel[7:0] == OFS_CONFIG);
    assign a_lo  = sel & (rel[7:0] == OFS_LO);
    assign a_hi  = sel & (rel[7:0] == OFS_HI);
    assign a_upd = sel & (rel[7:0] == OFS_UPDATE);
    assign a_alo = sel & (rel[7:0] == OFS_ALARMLO);
    assign a_ahi = sel & (rel[7:0] == OFS_ALARMHI);
    assign a_llo = sel & (rel[7:0] == OFS_LOADLO);
    assign a_lhi = sel & (rel[7:0] == OFS_LOADHI);
    assign a_ld  = sel & (rel[7:0] == OFS_LOAD);

    // register file; a software CONFIG write overrides the one-shot clear
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cfg <= '0;
        alarm <= '0;
        load_val <= '0;
      end else begin
        if (alarm_hit) cfg.alarm_en <= 1'b0;
        if (bus.wr_in && a_cfg) cfg <= cfg_unpack(bus.data_in);
        if (bus.wr_in && a_alo) alarm[31:0] <= bus.data_in;
        if (bus.wr_in && a_ahi) alarm[CNT_W-1:32] <= bus.data_in[HI_W-1:0];
        if (bus.wr_in && a_llo) load_val[31:0] <= bus.data_in;
        if (bus.wr_in && a_lhi) load_val[CNT_W-1:32] <= bus.data_in[HI_W-1:0];
      end
    end

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cfg      (cfg),
      .load     (bus.wr_in & a_ld),
      .update   (bus.wr_in & a_upd),
      .alarm    (alarm),
      .load_val (load_val),
      .snap     (snap),
      .alarm_hit(alarm_hit)
    );

    // per-channel read data, zero when not addressed
    always_comb begin
      rv = '0;
      unique case (1'b1)
        a_cfg: rv = cfg_pack(cfg);
        a_lo:  rv = snap[31:0];
        a_hi:  rv = 32'(snap >> 32);
        a_alo: rv = alarm[31:0];
        a_ahi: rv = 32'(alarm >> 32);
        a_llo: rv = load_val[31:0];
        a_lhi: rv = 32'(load_val >> 32);
        default: rv = '0;
      endcase
    end

    assign ch_rdata[c] = rv;
    assign hit_vec[c] = alarm_hit;
  end

  assign r_ena = off == (32'(INT_OFS) + 32'(INT_ENA_OFS));
  assign r_raw = off == (32'(INT_OFS) + 32'(INT_RAW_OFS));
  assign r_st  = off == (32'(INT_OFS) + 32'(INT_ST_OFS));
  assign w_ena = bus.wr_in & r_ena;
  assign w_clr = bus.wr_in & (off == (32'(INT_OFS) + 32'(INT_CLR_OFS)));
  assign clr_mask = w_clr ? bus.data_in[N_CH-1:0] : '0;
  assign st = raw & ena;
  assign bus.irq_out = st;

  // interrupt block; a same-edge alarm set beats the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena <= '0;
      raw <= '0;
    end else begin
      if (w_ena) ena <= bus.data_in[N_CH-1:0];
      raw <= (raw & ~clr_mask) | hit_vec;
    end
  end

  // read mux across channels and interrupt registers
  always_comb begin
    rmux = '0;
    for (int c = 0; c < N_CH; c++) rmux = rmux | ch_rdata[c];
    unique case (1'b1)
      r_ena:   rmux = 32'(ena);
      r_raw:   rmux = 32'(raw);
      r_st:    rmux = 32'(st);
      default: rmux = rmux;
    endcase
  end

  // one-cycle read response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_valid_out <= 1'b0;
      bus.data_out <= '0;
    end else begin
      bus.rd_valid_out <= bus.rd_in;
      if (bus.rd_in) bus.data_out <= rmux;
    end
  end

endmodule
